// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Reports a Mealy match flag, its registered copy and a saturating match count.
module seq_detect_param #(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_0101),
    parameter int                 DEF_LEN = 4,
    parameter bit                 DEF_OVL = 1'b1,
    localparam int                LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x_valid,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic               z_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0] hist_q, hist_d, hist_n;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_n;
    logic               ovl_q, ovl_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               zr_q;
    logic               mism;
    logic               shift_en;
    logic               cfg_ok;
    logic               z_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cfg_ok   = (cfg_len != '0) && (cfg_len <= MAX_L);
    assign shift_en = x_valid & ~cfg_load;

    // Compare the would-be history against the low len bits of the pattern.
    always_comb begin
        hist_n = {hist_q[MAX_LEN-2:0], x};
        fill_n = (fill_q == MAX_L) ? fill_q : fill_q + LEN_W'(1);
        mism   = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len_q) mism = mism | (hist_n[i] ^ pat_q[i]);
        end
        z_c = reset & shift_en & (fill_n >= len_q) & ~mism;
    end

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (cfg_load) begin
            if (cfg_ok) begin
                pat_d  = cfg_pat;
                len_d  = cfg_len;
                ovl_d  = cfg_overlap;
                hist_d = '0;
                fill_d = '0;
                err_d  = 1'b0;
            end else begin
                err_d  = 1'b1;
            end
        end else if (x_valid) begin
            hist_d = hist_n;
            // Non-overlapping mode forgets everything consumed by a match.
            fill_d = (z_c && !ovl_q) ? '0 : fill_n;
        end
        if (cnt_clr)  cnt_d = z_c ? CNT_W'(1) : '0;
        else if (z_c) cnt_d = sat_inc(cnt_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q  <= DEF_PAT;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVL;
            hist_q <= '0;
            fill_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            zr_q   <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            zr_q   <= z_c;
        end
    end

    assign z         = z_c;
    assign z_q       = zr_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = &cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param (MAX_LEN=8, CNT_W=2 so saturation is reachable).
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       x_valid;
    logic       x;
    logic       cfg_load;
    logic [7:0] cfg_pat;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       z;
    logic       z_q;
    logic [1:0] match_cnt;
    logic       cnt_sat;
    logic       cfg_err;

    int tests = 0;
    int fails = 0;

    seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .z(z), .z_q(z_q),
        .match_cnt(match_cnt), .cnt_sat(cnt_sat), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of serial input; z is checked before the rising edge.
    task automatic bit_in(input logic v, input logic b, input logic clr,
                          input logic exp_z, input string tag);
        @(negedge clk);
        x_valid = v; x = b; cnt_clr = clr;
        #1 chk(tag, {31'd0, z}, {31'd0, exp_z});
        @(posedge clk); #1;
        x_valid = 1'b0; x = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic v, input logic b, input string tag);
        @(negedge clk);
        cfg_load = 1'b1; cfg_pat = p; cfg_len = l; cfg_overlap = o;
        x_valid = v; x = b;
        #1 chk(tag, {31'd0, z}, 32'd0);
        @(posedge clk); #1;
        cfg_load = 1'b0; x_valid = 1'b0; x = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;
        reset = 1'b0; x_valid = 1'b0; x = 1'b0; cfg_load = 1'b0;
        cfg_pat = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_z",   {31'd0, z},       32'd0);
        chk("rst_zq",  {31'd0, z_q},     32'd0);
        chk("rst_cnt", {30'd0, match_cnt}, 32'd0);
        chk("rst_sat", {31'd0, cnt_sat}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        @(negedge clk); reset = 1'b1;

        // Default config 0101/len4/overlap
        bit_in(1, 0, 0, 0, "t1_b1");
        bit_in(1, 1, 0, 0, "t1_b2");
        bit_in(1, 0, 0, 0, "t1_b3");
        bit_in(1, 1, 0, 1, "t1_b4");
        bit_in(1, 0, 0, 0, "t1_b5");
        bit_in(1, 1, 0, 1, "t1_b6");
        chk("t1_zq",  {31'd0, z_q},       32'd1);
        chk("t1_cnt", {30'd0, match_cnt}, 32'd2);
        bit_in(0, 0, 1, 0, "clr1_z");
        chk("clr1_cnt", {30'd0, match_cnt}, 32'd0);

        // Non-overlapping 0101
        load(8'h05, 4'd4, 1'b0, 1'b1, 1'b1, "t2_load_z");
        chk("t2_err", {31'd0, cfg_err}, 32'd0);
        bit_in(1, 0, 0, 0, "t2_b1");
        bit_in(1, 1, 0, 0, "t2_b2");
        bit_in(1, 0, 0, 0, "t2_b3");
        bit_in(1, 1, 0, 1, "t2_b4");
        bit_in(1, 0, 0, 0, "t2_b5");
        bit_in(1, 1, 0, 0, "t2_b6");
        chk("t2_cnt", {30'd0, match_cnt}, 32'd1);

        // Illegal length keeps the 0101/overlap config
        load(8'h05, 4'd4, 1'b1, 1'b0, 1'b0, "t4_load_ok_z");
        load(8'hFF, 4'd9, 1'b0, 1'b1, 1'b0, "t4_load_bad_z");
        chk("t4_err", {31'd0, cfg_err}, 32'd1);
        bit_in(1, 0, 0, 0, "t4_b1");
        bit_in(1, 1, 0, 0, "t4_b2");
        bit_in(1, 0, 0, 0, "t4_b3");
        bit_in(1, 1, 0, 1, "t4_b4");
        bit_in(1, 0, 0, 0, "t4_b5");
        bit_in(1, 1, 0, 1, "t4_b6");
        chk("t4_cnt", {30'd0, match_cnt}, 32'd3);
        chk("t4_sat", {31'd0, cnt_sat},   32'd1);

        // Pattern 110 with idle gaps between bits
        load(8'h06, 4'd3, 1'b1, 1'b1, 1'b1, "t3_load_z");
        chk("t3_err", {31'd0, cfg_err}, 32'd0);
        bit_in(1, 1, 0, 0, "t3_b1");
        bit_in(0, 0, 0, 0, "t3_gap1");
        bit_in(1, 1, 0, 0, "t3_b2");
        bit_in(0, 1, 0, 0, "t3_gap2");
        bit_in(1, 0, 0, 1, "t3_b3");
        chk("t3_zq",  {31'd0, z_q},       32'd1);
        chk("t3_cnt", {30'd0, match_cnt}, 32'd3);
        bit_in(0, 0, 0, 0, "t3_idle");
        chk("t3_zq_drop", {31'd0, z_q}, 32'd0);

        // Saturation: five matches of 110 in a 2-bit counter
        bit_in(0, 0, 1, 0, "clr2_z");
        chk("clr2_cnt", {30'd0, match_cnt}, 32'd0);
        exp_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            bit_in(1, (k % 3 != 2), 0, (k % 3 == 2), "t5_bit");
            if (k % 3 == 2 && exp_cnt < 3) exp_cnt++;
            chk("t5_cnt", {30'd0, match_cnt}, exp_cnt);
        end
        chk("t5_sat", {31'd0, cnt_sat}, 32'd1);
        bit_in(1, 1, 0, 0, "t5_c1");
        bit_in(1, 1, 0, 0, "t5_c2");
        bit_in(1, 0, 1, 1, "t5_clr_match");
        chk("t5_clr_cnt", {30'd0, match_cnt}, 32'd1);
        chk("t5_clr_sat", {31'd0, cnt_sat},   32'd0);

        // Reset in the middle of a partial 0101
        load(8'h05, 4'd4, 1'b1, 1'b0, 1'b0, "t6_load_z");
        bit_in(1, 0, 0, 0, "t6_b1");
        bit_in(1, 1, 0, 0, "t6_b2");
        bit_in(1, 0, 0, 0, "t6_b3");
        load(8'h00, 4'd0, 1'b0, 1'b0, 1'b0, "t6_bad_z");
        chk("t6_err",     {31'd0, cfg_err},   32'd1);
        chk("t6_cnt_pre", {30'd0, match_cnt}, 32'd1);
        @(negedge clk);
        reset = 1'b0; x_valid = 1'b1; x = 1'b1;
        #1;
        chk("t6_rst_z",   {31'd0, z},         32'd0);
        chk("t6_rst_cnt", {30'd0, match_cnt}, 32'd0);
        chk("t6_rst_err", {31'd0, cfg_err},   32'd0);
        chk("t6_rst_zq",  {31'd0, z_q},       32'd0);
        @(posedge clk); #1;
        chk("t6_rst_z2",  {31'd0, z},         32'd0);
        @(negedge clk);
        reset = 1'b1; x_valid = 1'b0; x = 1'b0;
        bit_in(1, 1, 0, 0, "t6_b4");
        chk("t6_cnt", {30'd0, match_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 8: match counter width.
REQ-003 SHALL have parameter DEF_PAT, default 8'b0000_0101: pattern loaded at reset.
REQ-004 SHALL have parameter DEF_LEN, default 4: pattern length loaded at reset.
REQ-005 SHALL have parameter DEF_OVL, default 1: overlap mode loaded at reset.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port x_valid  input  1  x is sampled this cycle.
REQ-009 SHALL have port x  input  1  serial data bit.
REQ-010 SHALL have port cfg_load  input  1  load configuration this cycle.
REQ-011 SHALL have port cfg_pat  input  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
REQ-012 SHALL have port cfg_len  input  LEN_W=$clog2(MAX_LEN+1)  pattern length.
REQ-013 SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-014 SHALL have port cnt_clr  input  1  clear the match counter.
REQ-015 SHALL have port z  output  1  Mealy match flag, combinational, same cycle as the final pattern bit.
REQ-016 SHALL have port z_q  output  1  z registered (one-cycle delay).
REQ-017 SHALL have port match_cnt  output  CNT_W  saturating match count.
REQ-018 SHALL have port cnt_sat  output  1  match_cnt equals all-ones.
REQ-019 SHALL have port cfg_err  output  1  sticky flag: last load was illegal.

Function
REQ-020 SHALL hold active configuration (pat, len, ovl) in registers, a history shift register hist[MAX_LEN-1:0] (hist[0] newest), and a fill count 0..MAX_LEN.
REQ-021 SHALL, when x_valid=1 and cfg_load=0, shift: hist_n={hist[MAX_LEN-2:0],x}, fill_n=min(fill+1,MAX_LEN).
REQ-022 SHALL leave hist and fill unchanged when x_valid=0; z SHALL be 0 then.
REQ-023 SHALL assert z=1 iff x_valid=1, cfg_load=0, fill_n>=len and hist_n[i]==pat[i] for all i<len.
REQ-024 SHALL, on a match with ovl=1, store fill_n; with ovl=0, store fill=0 (history discarded).
REQ-025 SHALL, on cfg_load with 1<=cfg_len<=MAX_LEN, latch cfg_pat/cfg_len/cfg_overlap, clear hist and fill, clear cfg_err; new config applies from the next cycle.
REQ-026 SHALL, on cfg_load with cfg_len=0 or >MAX_LEN, keep config, hist and fill unchanged and set cfg_err=1.
REQ-027 SHALL ignore x during a cfg_load cycle (no shift, z=0).
REQ-028 SHALL increment match_cnt when z=1, saturating at 2^CNT_W-1.
REQ-029 SHALL, when cnt_clr=1 and z=1 in the same cycle, load match_cnt=1; when cnt_clr=1 alone, load 0.
REQ-030 SHALL update z_q <= z every cycle.

Reset
REQ-031 SHALL, while reset=0, force hist=0, fill=0, z_q=0, match_cnt=0, cfg_err=0, pat=DEF_PAT, len=DEF_LEN, ovl=DEF_OVL.
REQ-032 SHALL hold z=0 while reset=0; cnt_sat=0 at reset.
REQ-033 SHALL accept a reset assertion mid-sequence; partial history is lost, and no match SHALL complete across a reset.

Verification
REQ-034 SHALL cover: default config, x=0,1,0,1,0,1 (valid each cycle) -> z=1 on bits 4 and 6, match_cnt=2.
REQ-035 SHALL cover: load pat=8'h05, len=4, overlap=0, x=0,1,0,1,0,1 -> z=1 on bit 4 only, match_cnt=1.
REQ-036 SHALL cover: load pat=8'h06, len=3, x=1,1,0 with x_valid=0 gaps between bits -> z=1 on the cycle carrying the final 0, z_q=1 one cycle later.
REQ-037 SHALL cover: cfg_len=9 with MAX_LEN=8 -> cfg_err=1; x=0,1,0,1 then z=1 on bit 4 (old config retained).
REQ-038 SHALL cover: CNT_W=2, five matches -> match_cnt=3, cnt_sat=1; cnt_clr together with a match -> match_cnt=1.
REQ-039 SHALL cover: x=0,1,0, pulse reset low, then x=1 -> z=0, match_cnt=0.
